mem_access_ctrl: RTL and testbench
==================================

MEM_ACCESS_CTRL -- requirements
Module: mem_access_ctrl

Interface
REQ-001 SHALL have port Clk, input, 1 bit: single clock; all state updates occur on its rising edge.
REQ-002 SHALL have port Reset, input, 1 bit: reset, synchronous and active-low.
REQ-003 SHALL have port Req, input, 1 bit: access request, sampled only in IDLE.
REQ-004 SHALL have port IsStore, input, 1 bit: 1 = store, 0 = load.
REQ-005 SHALL have port Size, input, 2 bits: 00 = byte, 01 = halfword, 10 = word; 11 is treated as word.
REQ-006 SHALL have port SignExt, input, 1 bit: 1 = sign-extend sub-word loads, 0 = zero-extend.
REQ-007 SHALL have port Addr, input, 32 bits: byte address.
REQ-008 SHALL have port StoreData, input, 32 bits: store operand, with the sub-word value in the low bits.
REQ-009 SHALL have port Busy, output, 1 bit: high in every state except IDLE.
REQ-010 SHALL have port Done, output, 1 bit: one-cycle completion pulse.
REQ-011 SHALL have port Misaligned, output, 1 bit: pulses with Done when the access was rejected.
REQ-012 SHALL have port LoadData, output, 32 bits: registered load result.
REQ-013 SHALL have port MemAddress, output, 32 bits: word-aligned address to the data memory.
REQ-014 SHALL have port MemWriteData, output, 32 bits: full word written to the data memory.
REQ-015 SHALL have port MemWrite, output, 1 bit: data memory write strobe; the memory writes on the rising edge of Clk.
REQ-016 SHALL have port MemRead, output, 1 bit: data memory read enable.
REQ-017 SHALL have port MemReadData, input, 32 bits: combinational memory word; it is 0 when MemRead=0.

Function
REQ-018 SHALL implement the states IDLE, READ, WRITE and DONE.
REQ-019 SHALL, in IDLE with Req=1, capture Addr, IsStore, Size, SignExt and StoreData into internal registers; all later behaviour SHALL use only the captured values.
REQ-020 SHALL ignore Req in every state other than IDLE; no queueing.
REQ-021 SHALL treat an access as misaligned when it is a halfword with Addr[0]=1, or a word with Addr[1:0]!=00.
REQ-022 SHALL take a misaligned access IDLE->DONE with Misaligned=1, no MemRead, no MemWrite, and LoadData unchanged.
REQ-023 SHALL sequence a load as IDLE->READ->DONE: MemRead=1 in READ, with MemReadData captured at the end of READ.
REQ-024 SHALL sequence a word store as IDLE->WRITE->DONE: MemWrite=1 in WRITE, with MemWriteData=StoreData.
REQ-025 SHALL sequence a byte or halfword store as read-modify-write IDLE->READ->WRITE->DONE: the word read in READ has only the target lane replaced, and that merged word is written in WRITE.
REQ-026 SHALL always move DONE->IDLE after one cycle; Done=1 only in DONE.
REQ-027 SHALL use little-endian lanes: byte k = bits[8k+7:8k] with k=Addr[1:0]; halfword h = bits[16h+15:16h] with h=Addr[1].
REQ-028 SHALL, for a load, right-align the selected lane and sign- or zero-extend it to 32 bits according to SignExt, then register it into LoadData on entering DONE; LoadData SHALL hold between loads.
REQ-029 SHALL drive MemAddress = {captured Addr[31:2], 2'b00} in READ, WRITE and DONE, and 0 in IDLE.
REQ-030 SHALL drive MemWriteData to 0 in every state except WRITE.
REQ-031 SHALL drive MemRead and MemWrite as decodes of state only, never both high at once.
REQ-032 SHALL gate MemWrite low in any cycle where Reset=0, so that no memory write occurs on a reset edge.
REQ-033 SHALL have, counted from the Req-sampling edge to Done high: load 2 cycles, word store 2 cycles, sub-word store 3 cycles, misaligned access 1 cycle.
REQ-034 SHALL accept a new Req in the IDLE cycle immediately after DONE; the minimum back-to-back spacing is therefore 3 cycles for a load.

Reset
REQ-035 SHALL, at a rising edge of Clk with Reset=0, enter IDLE and set LoadData=0 and all captured registers to 0.
REQ-036 SHALL hold Busy, Done, Misaligned, MemRead, MemWrite, MemAddress and MemWriteData at 0 while in IDLE after reset.
REQ-037 SHALL, when reset occurs mid-operation in any state, abandon the access: no Done pulse is produced and the memory is left unmodified by that access.

Verification
REQ-038 Word store then load: store Addr=0x8, data 0xDEADBEEF, followed by a load word from 0x8 -> MemWrite=1 for exactly one cycle with MemAddress=0x8; Done pulses 2 cycles after each Req; LoadData=0xDEADBEEF.
REQ-039 Byte store RMW: memory[0x4]=0x11223344, store byte 0xAA at Addr=0x6 -> READ then WRITE with MemWriteData=0x11AA3344; Done 3 cycles after Req.
REQ-040 Sub-word loads from word 0x8000F0FF: LB at 0x0 with SignExt=1 -> 0xFFFFFFFF; LB with SignExt=0 -> 0x000000FF; LH at 0x2 with SignExt=1 -> 0xFFFF8000.
REQ-041 Misaligned: halfword load at 0x3 and word store at 0x2 -> Done and Misaligned pulse 1 cycle after Req; MemRead and MemWrite stay 0; LoadData unchanged.
REQ-042 Busy handling: Req held high continuously -> exactly one access per IDLE visit; Req pulses during READ/WRITE/DONE are ignored.
REQ-043 Reset mid-operation: Reset=0 during the WRITE cycle of a store -> MemWrite=0, memory unchanged, IDLE next cycle, no Done pulse, LoadData=0.

Source files
------------

// File: rtl/mem_access_ctrl_if.sv
// Request/response and data-memory bus for the load/store access controller.
interface mem_access_ctrl_if;
   logic        Req;
   logic        IsStore;
   logic [1:0]  Size;
   logic        SignExt;
   logic [31:0] Addr;
   logic [31:0] StoreData;
   logic        Busy;
   logic        Done;
   logic        Misaligned;
   logic [31:0] LoadData;
   logic [31:0] MemAddress;
   logic [31:0] MemWriteData;
   logic        MemWrite;
   logic        MemRead;
   logic [31:0] MemReadData;

   // Requester / memory model side
   modport master (
      output Req, IsStore, Size, SignExt, Addr, StoreData, MemReadData,
      input  Busy, Done, Misaligned, LoadData, MemAddress, MemWriteData, MemWrite, MemRead
   );

   // Controller side
   modport slave (
      input  Req, IsStore, Size, SignExt, Addr, StoreData, MemReadData,
      output Busy, Done, Misaligned, LoadData, MemAddress, MemWriteData, MemWrite, MemRead
   );
endinterface

// File: rtl/mem_access_ctrl.sv
// Load/store access controller: byte/halfword/word accesses to a word-wide
// data memory, with lane extraction/extension on loads and read-modify-write
// for sub-word stores. Misaligned accesses are rejected without touching memory.
module mem_access_ctrl (
   input  logic             Clk,
   input  logic             Reset,
   mem_access_ctrl_if.slave bus
);
   typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_t;

   state_t      state;
   logic        is_store_q, sext_q;
   logic [1:0]  size_q;
   logic [31:0] addr_q, sdata_q;
   logic        busy_q, done_q, mis_q, rd_q, wr_q;
   logic [31:0] load_q, wdata_q;

   logic        req_word, req_mis;
   logic [4:0]  shamt;
   logic [31:0] lane_raw, lane_mask, load_ext, merged;

   // Size 11 behaves as a word; alignment is judged on the live request
   assign req_word = bus.Size[1];
   assign req_mis  = (bus.Size == 2'b01 && bus.Addr[0]) ||
                     (req_word && bus.Addr[1:0] != 2'b00);

   // Lane position, right-aligned load value and merged store word for the captured access
   always_comb begin
      shamt     = 5'd0;
      lane_mask = 32'hFFFF_FFFF;
      if (!size_q[1]) begin
         shamt     = size_q[0] ? {addr_q[1], 4'b0000} : {addr_q[1:0], 3'b000};
         lane_mask = (size_q[0] ? 32'h0000_FFFF : 32'h0000_00FF) << shamt;
      end
      lane_raw = bus.MemReadData >> shamt;
      load_ext = lane_raw;
      if (!size_q[1]) begin
         if (size_q[0]) load_ext = {{16{sext_q & lane_raw[15]}}, lane_raw[15:0]};
         else           load_ext = {{24{sext_q & lane_raw[7]}},  lane_raw[7:0]};
      end
      merged = (bus.MemReadData & ~lane_mask) | ((sdata_q << shamt) & lane_mask);
   end

   // Access sequencer with registered strobes/outputs
   always_ff @(posedge Clk) begin
      if (!Reset) begin
         state      <= IDLE;
         is_store_q <= 1'b0;
         sext_q     <= 1'b0;
         size_q     <= 2'b00;
         addr_q     <= '0;
         sdata_q    <= '0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         mis_q      <= 1'b0;
         rd_q       <= 1'b0;
         wr_q       <= 1'b0;
         load_q     <= '0;
         wdata_q    <= '0;
      end else begin
         case (state)
            IDLE: if (bus.Req) begin
               is_store_q <= bus.IsStore;
               sext_q     <= bus.SignExt;
               size_q     <= bus.Size;
               addr_q     <= bus.Addr;
               sdata_q    <= bus.StoreData;
               busy_q     <= 1'b1;
               if (req_mis) begin
                  state  <= DONE;
                  done_q <= 1'b1;
                  mis_q  <= 1'b1;
               end else if (bus.IsStore && req_word) begin
                  state   <= WRITE;
                  wr_q    <= 1'b1;
                  wdata_q <= bus.StoreData;
               end else begin
                  // loads and sub-word stores both need the current word first
                  state <= READ;
                  rd_q  <= 1'b1;
               end
            end
            READ: begin
               rd_q <= 1'b0;
               if (is_store_q) begin
                  state   <= WRITE;
                  wr_q    <= 1'b1;
                  wdata_q <= merged;
               end else begin
                  state  <= DONE;
                  done_q <= 1'b1;
                  load_q <= load_ext;
               end
            end
            WRITE: begin
               state   <= DONE;
               wr_q    <= 1'b0;
               wdata_q <= '0;
               done_q  <= 1'b1;
            end
            DONE: begin
               state  <= IDLE;
               done_q <= 1'b0;
               mis_q  <= 1'b0;
               busy_q <= 1'b0;
            end
         endcase
      end
   end

   assign bus.Busy         = busy_q;
   assign bus.Done         = done_q;
   assign bus.Misaligned   = mis_q;
   assign bus.LoadData     = load_q;
   assign bus.MemRead      = rd_q;
   // no write may land on a reset edge
   assign bus.MemWrite     = wr_q & Reset;
   assign bus.MemWriteData = wdata_q;
   assign bus.MemAddress   = busy_q ? {addr_q[31:2], 2'b00} : 32'h0;
endmodule

// File: tb/tb_mem_access_ctrl.sv
// Randomized bench for mem_access_ctrl against a byte-addressed reference memory.
`timescale 1ns/1ps
module tb_mem_access_ctrl;
   logic Clk   = 1'b0;
   logic Reset = 1'b0;
   always #5 Clk = ~Clk;

   mem_access_ctrl_if bus();
   mem_access_ctrl dut (.Clk(Clk), .Reset(Reset), .bus(bus));

   // Data memory: 16 words, written on the rising edge, combinational read gated by MemRead
   logic [31:0] dmem [16] = '{default: 32'h0};
   always @(posedge Clk) if (bus.MemWrite) dmem[bus.MemAddress[5:2]] <= bus.MemWriteData;
   assign bus.MemReadData = bus.MemRead ? dmem[bus.MemAddress[5:2]] : 32'h0;

   // Reference: memory as bytes, last load result
   byte unsigned ref_mem [64];
   logic [31:0]  ref_load = 32'h0;
   int n_chk = 0;
   int n_err = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   function automatic int nbytes(input logic [1:0] sz);
      return (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
   endfunction

   function automatic logic [31:0] ref_word(input int idx);
      logic [31:0] w = 32'h0;
      for (int i = 0; i < 4; i++) w |= 32'(ref_mem[4*idx+i]) << (8*i);
      return w;
   endfunction

   task automatic do_op(input bit st, input logic [1:0] sz, input bit sx,
                        input logic [31:0] a, input logic [31:0] d);
      int n, lat, exp_lat, rd_cnt, wr_cnt;
      bit mis;
      logic [31:0] v, exp_wd;
      n   = nbytes(sz);
      mis = (a % n) != 0;
      if (!mis) begin
         if (st) begin
            for (int i = 0; i < n; i++) ref_mem[int'(a)+i] = d[8*i +: 8];
         end else begin
            v = 32'h0;
            for (int i = 0; i < n; i++) v |= 32'(ref_mem[int'(a)+i]) << (8*i);
            if (sx && n < 4 && v[8*n-1]) v |= 32'hFFFF_FFFF << (8*n);
            ref_load = v;
         end
      end
      exp_wd  = ref_word(int'(a[5:2]));
      exp_lat = mis ? 1 : (st && n < 4) ? 3 : 2;

      @(negedge Clk);
      check("idle_busy", 32'(bus.Busy), 32'd0);
      check("idle_done", 32'(bus.Done), 32'd0);
      bus.Req = 1'b1; bus.IsStore = st; bus.Size = sz; bus.SignExt = sx;
      bus.Addr = a; bus.StoreData = d;
      @(posedge Clk);
      lat = 0; rd_cnt = 0; wr_cnt = 0;
      for (int c = 1; c <= 8; c++) begin
         @(negedge Clk);
         // junk on the request side must be ignored while busy
         bus.Req = 1'($urandom_range(0, 1)); bus.IsStore = 1'($urandom);
         bus.Size = 2'($urandom); bus.SignExt = 1'($urandom);
         bus.Addr = $urandom; bus.StoreData = $urandom;
         rd_cnt += int'(bus.MemRead);
         wr_cnt += int'(bus.MemWrite);
         if (bus.MemRead && bus.MemWrite) check("rd_wr_excl", 32'd1, 32'd0);
         if (bus.MemRead) check("rd_addr", bus.MemAddress, {a[31:2], 2'b00});
         if (bus.MemWrite) begin
            check("wr_addr", bus.MemAddress, {a[31:2], 2'b00});
            check("wr_data", bus.MemWriteData, exp_wd);
         end
         if (bus.Done) begin lat = c; break; end
      end
      bus.Req = 1'b0;
      check("latency",    32'(lat), 32'(exp_lat));
      check("misaligned", 32'(bus.Misaligned), 32'(mis));
      check("busy_done",  32'(bus.Busy), 32'd1);
      check("load_data",  bus.LoadData, ref_load);
      check("mem_word",   dmem[a[5:2]], ref_word(int'(a[5:2])));
      check("rd_count",   32'(rd_cnt), 32'(!mis && (!st || n < 4)));
      check("wr_count",   32'(wr_cnt), 32'(!mis && st));
   endtask

   initial begin
      for (int i = 0; i < 64; i++) ref_mem[i] = 8'h00;
      bus.Req = 1'b0; bus.IsStore = 1'b0; bus.Size = 2'b00; bus.SignExt = 1'b0;
      bus.Addr = 32'h0; bus.StoreData = 32'h0;

      // reset state
      repeat (2) @(negedge Clk);
      check("rst_busy",  32'(bus.Busy), 32'd0);
      check("rst_done",  32'(bus.Done), 32'd0);
      check("rst_mis",   32'(bus.Misaligned), 32'd0);
      check("rst_rdwr",  32'({bus.MemRead, bus.MemWrite}), 32'd0);
      check("rst_maddr", bus.MemAddress, 32'h0);
      check("rst_wdata", bus.MemWriteData, 32'h0);
      check("rst_load",  bus.LoadData, 32'h0);
      Reset = 1'b1;

      // word store then load
      do_op(1, 2'd2, 0, 32'h8, 32'hDEAD_BEEF);
      do_op(0, 2'd2, 0, 32'h8, 32'h0);
      check("lw_deadbeef", bus.LoadData, 32'hDEAD_BEEF);

      // byte store read-modify-write
      do_op(1, 2'd2, 0, 32'h4, 32'h1122_3344);
      do_op(1, 2'd0, 0, 32'h6, 32'h1234_56AA);
      check("sb_merge", dmem[1], 32'h11AA_3344);

      // sub-word loads
      do_op(1, 2'd2, 0, 32'h0, 32'h8000_F0FF);
      do_op(0, 2'd0, 1, 32'h0, 32'h0);
      check("lb_sext", bus.LoadData, 32'hFFFF_FFFF);
      do_op(0, 2'd0, 0, 32'h0, 32'h0);
      check("lb_zext", bus.LoadData, 32'h0000_00FF);
      do_op(0, 2'd1, 1, 32'h2, 32'h0);
      check("lh_sext", bus.LoadData, 32'hFFFF_8000);

      // misaligned accesses
      do_op(0, 2'd1, 0, 32'h3, 32'h0);
      check("mis_lh_hold", bus.LoadData, 32'hFFFF_8000);
      do_op(1, 2'd2, 0, 32'h2, 32'h5555_5555);
      check("mis_sw_mem", dmem[0], 32'h8000_F0FF);

      // random traffic, some back-to-back, some with idle gaps
      for (int k = 0; k < 250; k++) begin
         if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) @(negedge Clk);
         do_op(1'($urandom), 2'($urandom), 1'($urandom), 32'($urandom_range(0, 63)), $urandom);
      end

      // reset during the WRITE cycle of a word store
      @(negedge Clk);
      bus.Req = 1'b1; bus.IsStore = 1'b1; bus.Size = 2'd2; bus.SignExt = 1'b0;
      bus.Addr = 32'h10; bus.StoreData = 32'hCAFE_F00D;
      @(posedge Clk);
      @(negedge Clk);
      bus.Req = 1'b0;
      check("mid_wr_before", 32'(bus.MemWrite), 32'd1);
      Reset = 1'b0;
      #1;
      check("mid_wr_gated", 32'(bus.MemWrite), 32'd0);
      @(posedge Clk);
      @(negedge Clk);
      Reset = 1'b1;
      ref_load = 32'h0;
      check("mid_busy", 32'(bus.Busy), 32'd0);
      check("mid_done", 32'(bus.Done), 32'd0);
      check("mid_load", bus.LoadData, ref_load);
      check("mid_mem",  dmem[4], ref_word(4));
      for (int c = 0; c < 4; c++) begin
         @(negedge Clk);
         check("mid_no_done", 32'({bus.Done, bus.Busy, bus.MemWrite}), 32'd0);
      end

      // controller still works after the abandoned access
      do_op(0, 2'd2, 0, 32'h10, 32'h0);

      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end
endmodule
